// File: rtl/adc_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo_if
// Data-bus bundle between the core and the ADC sample FIFO.
//   sel         : address-decode select for the block
//   addr        : byte address (block decodes addr[3:2])
//   wdata       : write data from the core
//   mem_rw      : 1 = write, 0 = read
//   mem_wstrobe : byte enables for writes
//   rdata       : registered read data back to the core
//   irq         : level interrupt to the core
// master = core side, slave = adc_sample_fifo side.
// ---------------------------------------------------------------------------
interface adc_sample_fifo_if;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_rw;
    logic [3:0]  mem_wstrobe;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output sel, addr, wdata, mem_rw, mem_wstrobe,
        input  rdata, irq
    );

    modport slave (
        input  sel, addr, wdata, mem_rw, mem_wstrobe,
        output rdata, irq
    );
endinterface

// File: rtl/adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo
// Memory-mapped ADC capture block. Samples adc_in every (divider+1) cycles
// while enabled and buffers the samples in a DEPTH-entry FIFO that the core
// drains through DATA reads. irq is high while count >= IRQ_LEVEL.
//
// Ports:
//   clk     : system clock, rising edge
//   nreset  : asynchronous active-low reset
//   adc_in  : 32-bit raw sample, synchronous to clk
//   bus     : adc_sample_fifo_if.slave (sel/addr/wdata/mem_rw/mem_wstrobe
//             in, rdata/irq out)
//
// Register map (addr[3:2]):
//   0 DATA   RO  FIFO head, read pops
//   1 STATUS RO  [0] empty, [1] full, [2] overflow (sticky), [15:8] count
//   2 CTRL   RW  [0] enable, [31:16] divider
//   3 CLEAR  WO  bit0 = 1 (byte 0 strobed) flushes FIFO, overflow, tick count
//
// Optional feature: define ADC_SAMPLE_AVG_EN to push the truncated mean of
// every four ticks instead of each raw tick.
// ---------------------------------------------------------------------------
module adc_sample_fifo #(
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [31:0]        adc_in,
    adc_sample_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          en_q, en_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   tick_q, tick_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;

    logic          rd, wr, data_rd, ctrl_wr, clr;
    logic [1:0]    idx;
    logic          full, empty, fire, pop, push, push_ok, ovf_set;
    logic [31:0]   push_data, status, count_ext;

    // addr/wdata bits outside the decoded fields are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[15:1]};

`ifdef ADC_SAMPLE_AVG_EN
    logic [33:0] acc_q, acc_d, acc_sum;
    logic [1:0]  phase_q, phase_d;
    logic        unused_avg;
    assign unused_avg = ^acc_sum[1:0];
`endif

    always_comb begin
        rd      = bus.sel && !bus.mem_rw;
        wr      = bus.sel &&  bus.mem_rw;
        idx     = bus.addr[3:2];
        data_rd = rd && (idx == 2'd0);
        ctrl_wr = wr && (idx == 2'd2);
        clr     = wr && (idx == 2'd3) && bus.mem_wstrobe[0] && bus.wdata[0];

        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        fire  = en_q && (tick_q == div_q);
        // a read on an empty FIFO returns 0 and leaves the pointers alone,
        // even if a sample lands on the same edge
        pop   = data_rd && !empty;

`ifdef ADC_SAMPLE_AVG_EN
        acc_sum   = acc_q + {2'b00, adc_in};
        push      = fire && (phase_q == 2'd3);
        push_data = acc_sum[33:2];
        acc_d     = acc_q;
        phase_d   = phase_q;
        if (clr || !en_q) begin
            acc_d   = '0;
            phase_d = '0;
        end else if (fire) begin
            acc_d   = (phase_q == 2'd3) ? '0 : acc_sum;
            phase_d = phase_q + 2'd1;
        end
`else
        push      = fire;
        push_data = adc_in;
`endif

        // full + pop on the same edge frees the slot the push needs
        push_ok = push && (!full || pop) && !clr;
        ovf_set = push && full && !pop && !clr;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        ovf_d = clr ? 1'b0 : (ovf_q || ovf_set);

        tick_d = tick_q + 16'd1;
        if (clr || !en_q || fire ||
            (ctrl_wr && (bus.mem_wstrobe[2] || bus.mem_wstrobe[3])))
            tick_d = '0;

        en_d  = en_q;
        div_d = div_q;
        if (ctrl_wr) begin
            if (bus.mem_wstrobe[0]) en_d        = bus.wdata[0];
            if (bus.mem_wstrobe[2]) div_d[7:0]  = bus.wdata[23:16];
            if (bus.mem_wstrobe[3]) div_d[15:8] = bus.wdata[31:24];
        end

        count_ext    = 32'(count_q);
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[2]    = ovf_q;
        status[15:8] = count_ext[7:0];

        rdata_d = rdata_q;
        if (rd) begin
            case (idx)
                2'd0:    rdata_d = pop ? mem[rd_ptr_q] : '0;
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {div_q, 15'd0, en_q};
                default: rdata_d = '0;
            endcase
        end

        irq_d = (int'(count_d) >= IRQ_LEVEL);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            div_q    <= '0;
            tick_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
`ifdef ADC_SAMPLE_AVG_EN
            acc_q    <= '0;
            phase_q  <= '0;
`endif
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
`ifdef ADC_SAMPLE_AVG_EN
            acc_q    <= acc_d;
            phase_q  <= phase_d;
`endif
        end
    end

    // storage needs no reset; contents are only visible through count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign bus.rdata = rdata_q;
    assign bus.irq   = irq_q;
endmodule
